// File: rtl/alu_cmd_dispatch.sv
// alu_cmd_dispatch: buffers ALU commands in a FIFO, issues them one at a time and holds each result for the consumer.
// Define DIVZERO_CHK_EN to answer divu-by-zero locally with an error result instead of issuing it.
module alu_cmd_dispatch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_valid,
  output logic [1:0]  alu_mode,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  input  logic        alu_ready,
  input  logic [63:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [1:0]  res_mode,
  output logic        res_err,
  output logic [AW:0] q_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;
  state_e        state_q, state_d;
  logic [1:0]    mode_mem [DEPTH];
  logic [31:0]   a_mem [DEPTH];
  logic [31:0]   b_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [1:0]    alu_mode_q, res_mode_q, res_mode_d;
  logic [31:0]   alu_a_q, alu_b_q;
  logic [63:0]   res_data_q, res_data_d;
  logic          full, empty, push, pop, div_zero;

  // Acceptance looks only at registered fullness, so a pop never frees a slot in the same cycle.
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push  = cmd_valid && !full;
  assign pop   = state_q == IDLE && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr_q] <= cmd_mode;
      a_mem[wr_ptr_q]    <= cmd_a;
      b_mem[wr_ptr_q]    <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      cnt_q    <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef DIVZERO_CHK_EN
  logic res_err_q;
  assign div_zero = mode_mem[rd_ptr_q] == 2'd1 && b_mem[rd_ptr_q] == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_err_q <= 1'b0;
    else if (pop) res_err_q <= div_zero;
  end
  assign res_err = res_err_q;
`else
  assign div_zero = 1'b0;
  assign res_err  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_mode_d = res_mode_q;
    case (state_q)
      IDLE: if (!empty) begin
        state_d    = div_zero ? HOLD : ISSUE;
        res_data_d = div_zero ? {a_mem[rd_ptr_q], 32'hFFFF_FFFF} : res_data_q;
        res_mode_d = div_zero ? mode_mem[rd_ptr_q] : res_mode_q;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (alu_ready) begin
        state_d    = HOLD;
        res_data_d = alu_out;
        res_mode_d = alu_mode_q;
      end
      HOLD: state_d = res_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_mode_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_data_q <= '0;
      res_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_mode_q <= res_mode_d;
      if (pop) begin
        alu_mode_q <= mode_mem[rd_ptr_q];
        alu_a_q    <= a_mem[rd_ptr_q];
        alu_b_q    <= b_mem[rd_ptr_q];
      end
    end
  end

  assign cmd_ready = !full;
  assign q_count   = cnt_q;
  assign alu_valid = state_q == ISSUE;
  assign alu_mode  = alu_mode_q;
  assign alu_in_A  = alu_a_q;
  assign alu_in_B  = alu_b_q;
  assign res_valid = state_q == HOLD;
  assign res_data  = res_data_q;
  assign res_mode  = res_mode_q;
endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// tb_alu_cmd_dispatch: scoreboard bench for alu_cmd_dispatch with a behavioural ALU responder.
// Honours DIVZERO_CHK_EN the same way the design does.
module tb_alu_cmd_dispatch;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int LAT_LONG = 33;
  localparam int LAT_SHORT = 2;
`ifdef DIVZERO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, res_ready = 1'b0, alu_ready = 1'b0;
  logic [1:0] cmd_mode = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [63:0] alu_out = '0;
  logic cmd_ready, alu_valid, res_valid, res_err;
  logic [1:0] alu_mode, res_mode;
  logic [31:0] alu_in_A, alu_in_B;
  logic [63:0] res_data;
  logic [AW:0] q_count;

  typedef struct packed {logic [1:0] m; logic [63:0] d; logic e;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic hold_prev = 1'b0, prev_e = 1'b0;
  logic [63:0] prev_d = '0;
  logic [1:0] prev_m = '0;

  always #5 clk = ~clk;

  alu_cmd_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_valid(alu_valid),
    .alu_mode(alu_mode), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B), .alu_ready(alu_ready),
    .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_mode(res_mode), .res_err(res_err), .q_count(q_count)
  );

  function automatic logic [63:0] ref_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0: return 64'(a) * 64'(b);
      2'd1: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      2'd2: return 64'(a >> b[4:0]);
      default: return 64'((33'(a) + 33'(b)) >> 1);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ALU responder: result after a fixed per-mode latency, plus stray ready pulses while idle.
  initial begin
    int cnt;
    logic [63:0] res;
    cnt = 0;
    res = '0;
    forever begin
      @(posedge clk);
      #1;
      alu_ready = 1'b0;
      alu_out = {$urandom, $urandom};
      if (!rst_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          alu_ready = 1'b1;
          alu_out = res;
        end
      end else if ($urandom_range(3) == 0) alu_ready = 1'b1;
      @(negedge clk);
      if (rst_n && alu_valid) begin
        res = ref_op(alu_mode, alu_in_A, alu_in_B);
        cnt = alu_mode[1] ? LAT_SHORT : LAT_LONG;
      end
    end
  end

  // Scoreboard and monitor; handshakes are judged mid-cycle and complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && hold_prev) begin
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", res_data, prev_d);
      chk("hold_res_mode", 64'(res_mode), 64'(prev_m));
      chk("hold_res_err", 64'(res_err), 64'(prev_e));
    end
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(res_valid), 64'd0);
      else begin
        chk("sb_res_data", res_data, sb[0].d);
        chk("sb_res_mode", 64'(res_mode), 64'(sb[0].m));
        chk("sb_res_err", 64'(res_err), 64'(sb[0].e));
        void'(sb.pop_front());
      end
    end
    if (rst_n && cmd_valid && cmd_ready)
      sb.push_back(exp_t'{m: cmd_mode, d: ref_op(cmd_mode, cmd_a, cmd_b),
                          e: CHK && cmd_mode == 2'd1 && cmd_b == 0});
    hold_prev <= rst_n && res_valid && !res_ready;
    prev_d <= res_data;
    prev_m <= res_mode;
    prev_e <= res_err;
  end

  task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    cmd_mode = m;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    if (!ok) chk("issue_timeout", 64'(ok), 64'd1);
  endtask

  // Push one command (its accepting edge closes cycle 0) and time alu_valid/res_valid over the following cycles.
  task automatic run_one(input string nm, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input int av_cyc, input int rv_cyc, input int n_av, input logic [63:0] exp_d,
                         input logic exp_e);
    int first_rv = -1, last_av = -1, cnt_av = 0;
    logic [63:0] d = '0;
    logic e = 1'b0;
    issue(m, a, b);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (alu_valid) begin
        cnt_av++;
        last_av = c;
      end
      if (res_valid && first_rv < 0) begin
        first_rv = c;
        d = res_data;
        e = res_err;
      end
      @(posedge clk);
      #1;
    end
    chk({nm, "_alu_valid_count"}, 64'(cnt_av), 64'(n_av));
    chk({nm, "_alu_valid_cycle"}, 64'(last_av), 64'(av_cyc));
    chk({nm, "_res_valid_cycle"}, 64'(first_rv), 64'(rv_cyc));
    chk({nm, "_res_data"}, d, exp_d);
    chk({nm, "_res_err"}, 64'(e), 64'(exp_e));
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      done = sb.size() == 0 && !res_valid && q_count == 0;
      @(posedge clk);
      #1;
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  initial begin
    int acc, n, guard, av_c, acc_c;
    bit seen, a_now;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_alu_ops", {alu_in_A, alu_in_B}, 64'd0);
    chk("rst_modes", 64'({alu_mode, res_mode}), 64'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;

    run_one("t1_mulu", 2'd0, 32'd3, 32'd5, 2, 36, 1, 64'd15, 1'b0);
    run_one("t2_divu", 2'd1, 32'd100, 32'd7, 2, 36, 1, {32'd2, 32'd14}, 1'b0);
    run_one("t2_shift", 2'd2, 32'hF0, 32'd4, 2, 5, 1, 64'h0F, 1'b0);
    run_one("avg_carry", 2'd3, 32'hFFFF_FFFF, 32'd1, 2, 5, 1, 64'h8000_0000, 1'b0);
    run_one("t6_div0", 2'd1, 32'd7, 32'd0, CHK ? -1 : 2, CHK ? 2 : 36, CHK ? 0 : 1,
            {32'd7, 32'hFFFF_FFFF}, CHK);

    // Back-to-back pushes while the consumer stalls: one in flight plus a full queue.
    res_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cmd_mode = 2'($urandom);
      cmd_a = $urandom;
      cmd_b = $urandom_range(1000) + 1;
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    chk("t3_accepted", 64'(acc), 64'd5);
    chk("t3_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("t3_q_count", 64'(q_count), 64'd4);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = res_valid;
      @(posedge clk);
      #1;
    end
    chk("t4_res_valid_reached", 64'(seen), 64'd1);
    acc = 0;
    av_c = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cmd_ready) acc++;
      if (alu_valid) av_c++;
      @(posedge clk);
      #1;
    end
    chk("t4_no_accept_while_full", 64'(acc), 64'd0);
    chk("t4_no_alu_valid_while_held", 64'(av_c), 64'd0);
    res_ready = 1'b1;
    av_c = -1;
    acc_c = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_now = cmd_valid && cmd_ready;
      if (a_now && acc_c < 0) acc_c = c;
      if (alu_valid && av_c < 0) av_c = c;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      if (a_now) cmd_valid = 1'b0;
    end
    chk("t4_sixth_accept_cycle", 64'(acc_c), 64'd2);
    chk("t4_next_alu_valid_cycle", 64'(av_c), 64'd2);
    drain("t4_drain");

    // Asynchronous reset while a mulu waits on the ALU with three commands queued.
    issue(2'd0, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) issue(2'd2, $urandom, 32'd1);
    chk("t5_pre_q_count", 64'(q_count), 64'd3);
    chk("t5_pre_res_valid", 64'(res_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_q_count", 64'(q_count), 64'd0);
    chk("t5_res_valid", 64'(res_valid), 64'd0);
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t5_alu_valid", 64'(alu_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_one("t5_after_reset", 2'd3, 32'd10, 32'd21, 2, 5, 1, 64'd15, 1'b0);

    // Randomised traffic with random consumer backpressure.
    n = 0;
    guard = 0;
    cmd_valid = 1'b0;
    while (n < 300 && guard < 40000) begin
      if (!cmd_valid && $urandom_range(1) == 1) begin
        cmd_mode = $urandom_range(9) < 3 ? 2'($urandom_range(1)) : 2'($urandom_range(3, 2));
        cmd_a = $urandom_range(3) == 0 ? 32'($urandom_range(300)) : $urandom;
        cmd_b = $urandom_range(7) == 0 ? 32'd0 : $urandom_range(3) == 0 ? 32'($urandom_range(40)) : $urandom;
        cmd_valid = 1'b1;
      end
      res_ready = $urandom_range(2) != 0;
      @(negedge clk);
      a_now = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      guard++;
      if (a_now) begin
        cmd_valid = 1'b0;
        n++;
      end
    end
    chk("rand_progress", 64'(n), 64'd300);
    drain("rand_drain");
    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
